// File: rtl/lb_pkg.sv
// Shared constants and index helpers for the line buffer.
// LB_EDGE_REPLICATE_EN switches window taps from wrap-around to right-border clamping.
package lb_pkg;

    localparam int LB_DATA_W = 8;
    localparam int LB_LINE_W = 512;
    localparam int LB_KSIZE  = 3;

    // Compare-and-clear so non-power-of-two depths wrap correctly.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
        if (ptr >= depth - 1) begin
            return 0;
        end
        return ptr + 1;
    endfunction

    function automatic int unsigned tap_index(input int unsigned base, input int unsigned k,
                                              input int unsigned depth);
        int unsigned sum;
        sum = base + k;
`ifdef LB_EDGE_REPLICATE_EN
        // Past the row end the border pixel is repeated instead of wrapping.
        if (sum > depth - 1) begin
            return depth - 1;
        end
        return sum;
`else
        if (sum >= depth) begin
            return sum - depth;
        end
        return sum;
`endif
    endfunction

endpackage

// File: rtl/lb_tap_select.sv
// Combinational read port for one window tap: resolves the tap address and selects the pixel.
module lb_tap_select
    import lb_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int LINE_W = LB_LINE_W,
    parameter int PTR_W  = $clog2(LINE_W),
    parameter int TAP    = 0
) (
    input  logic [DATA_W-1:0] mem [LINE_W],
    input  logic [PTR_W-1:0]  base,
    output logic [DATA_W-1:0] pixel
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        idx   = PTR_W'(tap_index(32'(base), 32'(TAP), 32'(LINE_W)));
        pixel = mem[idx];
    end

endmodule

// File: rtl/line_buffer_win.sv
// Single-row pixel buffer with a KSIZE-tap horizontal window, occupancy flags and sticky errors.
// Optional build macro: LB_EDGE_REPLICATE_EN (clamp taps at the row end instead of wrapping).
module line_buffer_win
    import lb_pkg::*;
#(
    parameter int DATA_W = LB_DATA_W,
    parameter int LINE_W = LB_LINE_W,
    parameter int KSIZE  = LB_KSIZE,
    parameter int PTR_W  = $clog2(LINE_W),
    parameter int CNT_W  = $clog2(LINE_W + 1)
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [DATA_W-1:0]         i_data,
    input  logic                      i_data_valid,
    input  logic                      i_rd_data,
    output logic [KSIZE*DATA_W-1:0]   o_data,
    output logic [CNT_W-1:0]          o_count,
    output logic                      o_empty,
    output logic                      o_full,
    output logic                      o_line_done,
    output logic                      o_ovf_err,
    output logic                      o_unf_err
);

    logic [DATA_W-1:0] mem [LINE_W];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [PTR_W-1:0]  rd_ptr_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic              wr_ok;
    logic              rd_ok;

    // Acceptance uses the flags registered before this edge.
    always_comb begin
        wr_ok      = i_data_valid && !o_full;
        rd_ok      = i_rd_data && !o_empty;
        wr_ptr_nxt = PTR_W'(next_ptr(32'(wr_ptr), 32'(LINE_W)));
        rd_ptr_nxt = PTR_W'(next_ptr(32'(rd_ptr), 32'(LINE_W)));
        count_nxt  = o_count;
        case ({wr_ok, rd_ok})
            2'b10:   count_nxt = o_count + CNT_W'(1);
            2'b01:   count_nxt = o_count - CNT_W'(1);
            default: count_nxt = o_count;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_count     <= '0;
            o_empty     <= 1'b1;
            o_full      <= 1'b0;
            o_line_done <= 1'b0;
            o_ovf_err   <= 1'b0;
            o_unf_err   <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr_nxt;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr_nxt;
            end
            o_count     <= count_nxt;
            o_empty     <= (count_nxt == '0);
            o_full      <= (count_nxt == CNT_W'(LINE_W));
            o_line_done <= wr_ok && (wr_ptr == PTR_W'(LINE_W - 1));
            if (i_data_valid && o_full) begin
                o_ovf_err <= 1'b1;
            end
            if (i_rd_data && o_empty) begin
                o_unf_err <= 1'b1;
            end
        end
    end

    // Tap 0 sits in the most significant slice of the window.
    for (genvar k = 0; k < KSIZE; k++) begin : g_tap
        lb_tap_select #(
            .DATA_W (DATA_W),
            .LINE_W (LINE_W),
            .PTR_W  (PTR_W),
            .TAP    (k)
        ) u_tap (
            .mem   (mem),
            .base  (rd_ptr),
            .pixel (o_data[(KSIZE-1-k)*DATA_W +: DATA_W])
        );
    end

endmodule
